// File: rtl/core_ctrl_fsm_pkg.sv
// Shared types for the RV32I multi-cycle control sequencer.
//   opcode_map   : one-hot opcode flags produced by the decoder
//   ctrl_state_e : sequencer states (visible on state_o)
//   pc_sel_e     : PC source select driven alongside pc_we_o
//   wb_sel_e     : register-file write-back source select
//   trap_cause_e : reason recorded on trap entry
package core_ctrl_fsm_pkg;

  typedef struct packed {
    logic system;
    logic misc_mem;
    logic op;
    logic op_imm;
    logic store;
    logic load;
    logic branch;
    logic jalr;
    logic jal;
    logic auipc;
    logic lui;
  } opcode_map;

  typedef enum logic [3:0] {
    ST_RESET      = 4'd0,
    ST_FETCH      = 4'd1,
    ST_FETCH_WAIT = 4'd2,
    ST_DECODE     = 4'd3,
    ST_EXEC       = 4'd4,
    ST_MEM        = 4'd5,
    ST_MEM_WAIT   = 4'd6,
    ST_WB         = 4'd7,
    ST_TRAP       = 4'd8
  } ctrl_state_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_TARGET = 2'd1,
    PC_JALR   = 2'd2,
    PC_TRAPV  = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_ALU   = 2'd0,
    WB_LOAD  = 2'd1,
    WB_PC4   = 2'd2,
    WB_IMM_U = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_ILLEGAL  = 2'd1,
    CAUSE_IMEM_TMO = 2'd2,
    CAUSE_DMEM_TMO = 2'd3
  } trap_cause_e;

  // Opcodes this core can execute; anything else (FENCE, SYSTEM, none) traps.
  function automatic logic op_supported(input opcode_map m);
    return m.load | m.store | m.branch | m.jal | m.jalr |
           m.lui | m.auipc | m.op | m.op_imm;
  endfunction

  function automatic logic op_writes_rd(input opcode_map m);
    return m.op | m.op_imm | m.lui | m.auipc | m.load | m.jal | m.jalr;
  endfunction

endpackage

// File: rtl/core_ctrl_fsm_bus_wait_timer.sv
// Bus wait timer: counts cycles spent waiting on a bus handshake.
//   clk_i, rst_ni : clock / async active-low reset
//   clear_i       : restart count at 0 (takes priority over enable_i)
//   enable_i      : count this cycle
//   expired_o     : this is the last allowed wait cycle; without the awaited
//                   handshake now, the next edge must leave for TRAP
module core_ctrl_fsm_bus_wait_timer #(
  parameter int TIMEOUT_W = 8,
  parameter int MAX_WAIT  = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [TIMEOUT_W-1:0] LAST_CYC = TIMEOUT_W'(MAX_WAIT - 1);
  localparam logic [TIMEOUT_W-1:0] SAT_VAL  = TIMEOUT_W'(MAX_WAIT);

  logic [TIMEOUT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (clear_i) begin
      cnt <= '0;
    end else if (enable_i && (cnt != SAT_VAL)) begin
      cnt <= cnt + TIMEOUT_W'(1);
    end
  end

  // cnt equals the number of cycles already spent in the current wait state.
  assign expired_o = enable_i && (cnt >= LAST_CYC);

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I core.
//   imem_req_o / imem_gnt_i / imem_rvalid_i : instruction fetch handshake
//   dmem_req_o / dmem_we_o / dmem_gnt_i / dmem_rvalid_i : data access handshake
//   op_decode_i, illegal_i : decoder results, sampled in DECODE
//   branch_taken_i         : ALU compare result, sampled in EXEC
//   ir_we_o, pc_we_o, pc_sel_o, rf_we_o, wb_sel_o : datapath strobes/selects
//   state_o                : current state for debug
//   trap_o, trap_cause_o   : trap entry pulse and sticky cause
//   instret_o              : retire pulse
module core_ctrl_fsm
  import core_ctrl_fsm_pkg::*;
#(
  parameter int TIMEOUT_W = 8,
  parameter int MAX_WAIT  = 255
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic       imem_req_o,
  input  logic       imem_gnt_i,
  input  logic       imem_rvalid_i,
  output logic       dmem_req_o,
  output logic       dmem_we_o,
  input  logic       dmem_gnt_i,
  input  logic       dmem_rvalid_i,
  input  opcode_map  op_decode_i,
  input  logic       illegal_i,
  input  logic       branch_taken_i,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic [1:0] pc_sel_o,
  output logic       rf_we_o,
  output logic [1:0] wb_sel_o,
  output logic [3:0] state_o,
  output logic       trap_o,
  output logic [1:0] trap_cause_o,
  output logic       instret_o
);

  ctrl_state_e state_q, state_d;
  trap_cause_e cause_d;
  opcode_map   op_q;
  logic        taken_q;
  logic        taken_wb;
  logic        wait_en;
  logic        tmo;

  assign wait_en = (state_q == ST_FETCH) || (state_q == ST_FETCH_WAIT) ||
                   (state_q == ST_MEM)   || (state_q == ST_MEM_WAIT);

  core_ctrl_fsm_bus_wait_timer #(
    .TIMEOUT_W (TIMEOUT_W),
    .MAX_WAIT  (MAX_WAIT)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (state_d != state_q),
    .enable_i  (wait_en),
    .expired_o (tmo)
  );

  always_comb begin
    state_d = state_q;
    cause_d = CAUSE_NONE;
    unique case (state_q)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_gnt_i && imem_rvalid_i) state_d = ST_DECODE;
        else if (imem_gnt_i)             state_d = ST_FETCH_WAIT;
        else if (tmo) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_IMEM_TMO;
        end
      end
      ST_FETCH_WAIT: begin
        if (imem_rvalid_i) state_d = ST_DECODE;
        else if (tmo) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_IMEM_TMO;
        end
      end
      ST_DECODE: begin
        if (illegal_i || !op_supported(op_decode_i)) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: state_d = (op_q.load || op_q.store) ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (dmem_gnt_i && dmem_rvalid_i) state_d = ST_WB;
        else if (dmem_gnt_i)             state_d = ST_MEM_WAIT;
        else if (tmo) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_DMEM_TMO;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_rvalid_i) state_d = ST_WB;
        else if (tmo) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_DMEM_TMO;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_FETCH;
      default: state_d = ST_RESET;
    endcase
  end

  // Outputs are registered from the next state, so they line up with state_q.
  // A branch goes EXEC->WB directly, so the compare result is taken live then.
  assign taken_wb = (state_q == ST_EXEC) ? branch_taken_i : taken_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_RESET;
      op_q         <= '0;
      taken_q      <= 1'b0;
      imem_req_o   <= 1'b0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      pc_we_o      <= 1'b0;
      pc_sel_o     <= PC_PLUS4;
      rf_we_o      <= 1'b0;
      wb_sel_o     <= WB_ALU;
      trap_o       <= 1'b0;
      trap_cause_o <= CAUSE_NONE;
      instret_o    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) op_q    <= op_decode_i;
      if (state_q == ST_EXEC)   taken_q <= branch_taken_i;

      imem_req_o <= (state_d == ST_FETCH);
      dmem_req_o <= (state_d == ST_MEM);
      dmem_we_o  <= (state_d == ST_MEM) && op_q.store;
      pc_we_o    <= (state_d == ST_WB) || (state_d == ST_TRAP);
      rf_we_o    <= (state_d == ST_WB) && op_writes_rd(op_q);
      trap_o     <= (state_d == ST_TRAP);
      instret_o  <= (state_d == ST_WB);

      pc_sel_o <= PC_PLUS4;
      if (state_d == ST_TRAP) begin
        pc_sel_o <= PC_TRAPV;
      end else if (state_d == ST_WB) begin
        if (op_q.jalr)                            pc_sel_o <= PC_JALR;
        else if (op_q.jal || (op_q.branch && taken_wb)) pc_sel_o <= PC_TARGET;
      end

      wb_sel_o <= WB_ALU;
      if (state_d == ST_WB) begin
        if (op_q.load)                  wb_sel_o <= WB_LOAD;
        else if (op_q.jal || op_q.jalr) wb_sel_o <= WB_PC4;
        else if (op_q.lui)              wb_sel_o <= WB_IMM_U;
      end

      if (state_d == ST_TRAP) trap_cause_o <= cause_d;
    end
  end

  // IR capture is combinational on rvalid so the word is latched the cycle it arrives.
  assign ir_we_o = imem_rvalid_i &&
                   ((state_q == ST_FETCH_WAIT) || ((state_q == ST_FETCH) && imem_gnt_i));

  assign state_o = state_q;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
module tb_core_ctrl_fsm;
  import core_ctrl_fsm_pkg::*;

  localparam int MAXW = 12;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic       dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i;
  opcode_map  op_decode_i;
  logic       illegal_i, branch_taken_i;
  logic       ir_we_o, pc_we_o, rf_we_o, trap_o, instret_o;
  logic [1:0] pc_sel_o, wb_sel_o, trap_cause_o;
  logic [3:0] state_o;

  int checks   = 0;
  int failures = 0;

  core_ctrl_fsm #(.TIMEOUT_W(8), .MAX_WAIT(MAXW)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .imem_req_o     (imem_req_o),
    .imem_gnt_i     (imem_gnt_i),
    .imem_rvalid_i  (imem_rvalid_i),
    .dmem_req_o     (dmem_req_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_gnt_i     (dmem_gnt_i),
    .dmem_rvalid_i  (dmem_rvalid_i),
    .op_decode_i    (op_decode_i),
    .illegal_i      (illegal_i),
    .branch_taken_i (branch_taken_i),
    .ir_we_o        (ir_we_o),
    .pc_we_o        (pc_we_o),
    .pc_sel_o       (pc_sel_o),
    .rf_we_o        (rf_we_o),
    .wb_sel_o       (wb_sel_o),
    .state_o        (state_o),
    .trap_o         (trap_o),
    .trap_cause_o   (trap_cause_o),
    .instret_o      (instret_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Starting in FETCH: gnt for one cycle, then rvalid for one cycle; ends in DECODE.
  task automatic fetch_to_decode(input string tag);
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    chk({tag, "_fwait"}, state_o, 32'(ST_FETCH_WAIT));
    chk({tag, "_ireq_drop"}, imem_req_o, 0);
    imem_rvalid_i = 1'b1;
    #1;
    chk({tag, "_ir_we"}, ir_we_o, 1);
    step();
    imem_rvalid_i = 1'b0;
    chk({tag, "_decode"}, state_o, 32'(ST_DECODE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_ni = 1'b0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    op_decode_i = '0; illegal_i = 1'b0; branch_taken_i = 1'b0;

    // Reset state
    step(); step();
    chk("rst_state", state_o, 32'(ST_RESET));
    chk("rst_outs", {imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o, pc_sel_o,
                     rf_we_o, wb_sel_o, trap_o, trap_cause_o, instret_o}, 0);

    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    chk("first_fetch", state_o, 32'(ST_FETCH));
    chk("first_ireq", imem_req_o, 1);

    // ADDI x1,x0,5 (0x00500093) -> OP_IMM
    op_decode_i = '0; op_decode_i.op_imm = 1'b1;
    fetch_to_decode("addi");
    step();
    chk("addi_exec", state_o, 32'(ST_EXEC));
    step();
    chk("addi_wb", state_o, 32'(ST_WB));
    chk("addi_wb_strobes", {instret_o, pc_we_o, rf_we_o, wb_sel_o, pc_sel_o}, 32'b1110000);
    step();
    chk("addi_back_fetch", state_o, 32'(ST_FETCH));
    chk("addi_pulse_end", {instret_o, pc_we_o, rf_we_o}, 0);

    // LW x2,0(x1) (0x0000A103), dmem grant delayed 3 cycles
    op_decode_i = '0; op_decode_i.load = 1'b1;
    fetch_to_decode("lw");
    step(); step();
    chk("lw_mem", state_o, 32'(ST_MEM));
    chk("lw_we", dmem_we_o, 0);
    n = int'(dmem_req_o);
    repeat (3) begin
      step();
      n += int'(dmem_req_o);
    end
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    chk("lw_req_cycles", n, 4);
    chk("lw_mem_wait", state_o, 32'(ST_MEM_WAIT));
    chk("lw_req_drop", dmem_req_o, 0);
    dmem_rvalid_i = 1'b1;
    step();
    dmem_rvalid_i = 1'b0;
    chk("lw_wb", {state_o, rf_we_o, wb_sel_o, instret_o}, {4'(ST_WB), 1'b1, 2'd1, 1'b1});
    step();

    // SW x2,0(x1) (0x0020A023), gnt and rvalid together
    op_decode_i = '0; op_decode_i.store = 1'b1;
    fetch_to_decode("sw");
    step(); step();
    chk("sw_mem_we", {dmem_req_o, dmem_we_o}, 2'b11);
    dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    chk("sw_wb", {state_o, rf_we_o, pc_we_o, dmem_req_o}, {4'(ST_WB), 1'b0, 1'b1, 1'b0});
    step();

    // BEQ x0,x0,0 (0x00000063), taken
    op_decode_i = '0; op_decode_i.branch = 1'b1;
    fetch_to_decode("beq");
    step();
    branch_taken_i = 1'b1;
    step();
    branch_taken_i = 1'b0;
    chk("beq_wb", {state_o, pc_sel_o, rf_we_o, instret_o}, {4'(ST_WB), 2'd1, 1'b0, 1'b1});
    step();

    // JALR
    op_decode_i = '0; op_decode_i.jalr = 1'b1;
    fetch_to_decode("jalr");
    step(); step();
    chk("jalr_wb", {pc_sel_o, wb_sel_o, rf_we_o}, {2'd2, 2'd2, 1'b1});
    step();

    // Word 0x00000000 flagged illegal
    op_decode_i = '0; illegal_i = 1'b1;
    fetch_to_decode("ill");
    step();
    illegal_i = 1'b0;
    chk("ill_trap", {state_o, trap_o, trap_cause_o, pc_sel_o, pc_we_o, rf_we_o, instret_o},
        {4'(ST_TRAP), 1'b1, 2'd1, 2'd3, 1'b1, 1'b0, 1'b0});
    step();
    chk("ill_after", {state_o, trap_o, trap_cause_o}, {4'(ST_FETCH), 1'b0, 2'd1});

    // imem grant never arrives -> trap exactly MAXW cycles after FETCH entry
    repeat (MAXW - 1) step();
    chk("itmo_not_yet", {state_o, trap_o}, {4'(ST_FETCH), 1'b0});
    step();
    chk("itmo_trap", {state_o, trap_o, trap_cause_o}, {4'(ST_TRAP), 1'b1, 2'd2});
    step();
    chk("itmo_refetch", state_o, 32'(ST_FETCH));

    // grant in the last allowed cycle -> no trap
    repeat (MAXW - 1) step();
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    chk("igrant_late_ok", {state_o, trap_o}, {4'(ST_FETCH_WAIT), 1'b0});

    // dmem grant never arrives -> trap cause 3
    op_decode_i = '0; op_decode_i.load = 1'b1;
    imem_rvalid_i = 1'b1;
    step();
    imem_rvalid_i = 1'b0;
    step(); step();
    chk("dtmo_mem", state_o, 32'(ST_MEM));
    repeat (MAXW - 1) step();
    chk("dtmo_not_yet", state_o, 32'(ST_MEM));
    step();
    chk("dtmo_trap", {state_o, trap_o, trap_cause_o, dmem_req_o}, {4'(ST_TRAP), 1'b1, 2'd3, 1'b0});
    step();

    // Reset during MEM_WAIT with rvalid during and just after reset
    fetch_to_decode("rstmw");
    step(); step();
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    chk("rstmw_wait", state_o, 32'(ST_MEM_WAIT));
    #2;
    rst_ni = 1'b0;
    dmem_rvalid_i = 1'b1;
    #1;
    chk("rstmw_async", {state_o, dmem_req_o, imem_req_o, pc_we_o}, 0);
    step();
    chk("rstmw_held", {state_o, instret_o, rf_we_o}, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    chk("rstmw_restart", {state_o, imem_req_o, instret_o, rf_we_o}, {4'(ST_FETCH), 1'b1, 1'b0, 1'b0});
    dmem_rvalid_i = 1'b0;
    imem_rvalid_i = 1'b1;
    #1;
    chk("stray_rvalid_ir", ir_we_o, 0);
    step();
    imem_rvalid_i = 1'b0;
    chk("stray_rvalid_state", state_o, 32'(ST_FETCH));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
